// File: rtl/tpu_mac_unit.sv
// Sequential shift-add multiply-accumulate engine: DATA_W-cycle multiply, then
// overwrite or add into an ACC_W-bit accumulator read out as two OUT_W halves.
module tpu_mac_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              accumulate,
    input  logic              out_HL,
    input  logic [DATA_W-1:0] input1,
    input  logic [DATA_W-1:0] input2,
    output logic              ready,
    output logic              done,
    output logic              error,
    output logic [OUT_W-1:0]  out
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PROD_W-1:0]   r_mcand;
    logic [PROD_W-1:0]   r_prod;
    logic [PROD_W-1:0]   w_prod_next;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_acc_mode;
    logic [ACC_W-1:0]    r_acc;
    logic                r_error;
    logic                w_accept;
    logic                w_reject;
    logic                w_last;
    logic [ACC_W:0]      w_sum;
    logic [2*OUT_W-1:0]  w_acc_ext;

    assign ready    = (r_state != S_MUL);
    assign done     = (r_state == S_DONE);
    assign error    = r_error;
    assign w_accept = sync & ready;
    assign w_reject = sync & ~ready;
    assign w_last   = (r_state == S_MUL) && (r_cnt == CNT_W'(DATA_W - 1));

    // Partial product including the current multiplier bit; on the last MUL
    // edge this is the full product, so the accumulator uses it directly.
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_sum = r_acc_mode ? ({1'b0, r_acc} + (ACC_W+1)'(w_prod_next))
                              : (ACC_W+1)'(w_prod_next);

    assign w_acc_ext = (2*OUT_W)'(r_acc);
    assign out       = out_HL ? w_acc_ext[2*OUT_W-1:OUT_W] : w_acc_ext[OUT_W-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_MUL;
            S_MUL:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_MUL : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_prod     <= '0;
            r_cnt      <= '0;
            r_acc_mode <= 1'b0;
            r_acc      <= '0;
            r_error    <= 1'b0;
        end else begin
            if (w_reject) r_error <= 1'b1;
            if (w_accept) begin
                r_mcand    <= PROD_W'(input1);
                r_mplier   <= input2;
                r_acc_mode <= accumulate;
                r_prod     <= '0;
                r_cnt      <= '0;
            end else if (r_state == S_MUL) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_acc <= w_sum[ACC_W-1:0];
                    if (w_sum[ACC_W]) r_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tpu_mac_unit.sv
// Self-checking bench for tpu_mac_unit: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level behavioural model.
module tb_tpu_mac_unit;

    localparam int  DW   = 8;
    localparam int  AW   = 24;
    localparam int  OW   = 16;
    localparam longint MASK = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sync = 1'b0;
    logic          accumulate = 1'b0;
    logic          out_HL = 1'b0;
    logic [DW-1:0] input1 = '0;
    logic [DW-1:0] input2 = '0;
    logic          ready;
    logic          done;
    logic          error;
    logic [OW-1:0] out;

    int errs = 0;
    int checks = 0;

    tpu_mac_unit #(.DATA_W(DW), .ACC_W(AW), .OUT_W(OW)) dut (
        .clk(clk), .reset(reset), .sync(sync), .accumulate(accumulate),
        .out_HL(out_HL), .input1(input1), .input2(input2),
        .ready(ready), .done(done), .error(error), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation occupies DW busy cycles after acceptance; the
    // result lands on the edge that ends the busy period.
    int     m_busy = 0;
    longint m_acc = 0;
    longint m_a = 0;
    longint m_b = 0;
    longint m_full;
    bit     m_mode = 1'b0;
    bit     m_err = 1'b0;
    bit     m_done = 1'b0;
    bit     m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy  <= 0;
            m_acc   <= 0;
            m_err   <= 1'b0;
            m_done  <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_busy > 0) begin
                if (sync) m_err <= 1'b1;
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_full = (m_mode ? m_acc : 0) + m_a * m_b;
                    m_acc  <= m_full & MASK;
                    if (m_full > MASK) m_err <= 1'b1;
                    m_done <= 1'b1;
                end
            end else if (sync) begin
                m_a    <= longint'(input1);
                m_b    <= longint'(input2);
                m_mode <= accumulate;
                m_busy <= DW;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("ready", longint'(ready), longint'(m_busy == 0));
            chk("done",  longint'(done),  longint'(m_done));
            chk("error", longint'(error), longint'(m_err));
            chk("out",   longint'(out),   (m_acc >> (out_HL ? OW : 0)) & 16'hFFFF);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start(input int a, input int b, input bit m);
        sync       = 1'b1;
        input1     = DW'(a);
        input2     = DW'(b);
        accumulate = m;
        cyc(1);
        sync       = 1'b0;
        input1     = DW'($urandom);
        input2     = DW'($urandom);
        accumulate = 1'($urandom);
    endtask

    task automatic run(input int a, input int b, input bit m);
        start(a, b, m);
        cyc(DW);
    endtask

    task automatic lit_out(input string name, input longint lo, input longint hi);
        out_HL = 1'b0;
        #1 chk({name, "_lo"}, longint'(out), lo);
        out_HL = 1'b1;
        #1 chk({name, "_hi"}, longint'(out), hi);
        out_HL = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        sync  = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        cyc(1);
        do_reset();
        chk("rst_ready", longint'(ready), 1);
        chk("rst_done",  longint'(done), 0);
        chk("rst_error", longint'(error), 0);
        lit_out("rst_out", 0, 0);

        // 13 x 15, overwrite
        start(13, 15, 1'b0);
        for (int i = 1; i <= DW; i++) begin
            chk("mul_ready_low", longint'(ready), 0);
            if (i < DW) cyc(1);
        end
        cyc(1);
        chk("t1_done", longint'(done), 1);
        chk("t1_ready", longint'(ready), 1);
        lit_out("t1_out", 16'h00C3, 16'h0000);
        chk("t1_error", longint'(error), 0);
        cyc(1);
        chk("t1_done_pulse", longint'(done), 0);

        // 255 x 255 then accumulate, second synced in the DONE cycle
        run(255, 255, 1'b0);
        chk("t2a_done", longint'(done), 1);
        lit_out("t2a_out", 16'hFE01, 16'h0000);
        run(255, 255, 1'b1);
        chk("t2b_done", longint'(done), 1);
        lit_out("t2b_out", 16'hFC02, 16'h0001);

        // 259 back-to-back operations driving the accumulator to overflow
        do_reset();
        run(255, 255, 1'b0);
        for (int k = 2; k <= 259; k++) begin
            run(255, 255, 1'b1);
            if (k == 258) begin
                lit_out("t3_258_out", 16'hFD02, 16'h00FF);
                chk("t3_258_error", longint'(error), 0);
            end
        end
        lit_out("t3_259_out", 16'hFB03, 16'h0000);
        chk("t3_259_error", longint'(error), 1);
        chk("t3_259_done", longint'(done), 1);
        cyc(3);
        chk("t3_error_sticky", longint'(error), 1);

        // Rejected sync in cycle 3
        do_reset();
        start(13, 15, 1'b0);
        cyc(2);
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
        chk("t4_error", longint'(error), 1);
        chk("t4_ready", longint'(ready), 0);
        cyc(DW - 3);
        chk("t4_done", longint'(done), 1);
        lit_out("t4_out", 16'h00C3, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("t4_no_second_done", longint'(done), 0);
        end

        // Reset mid-multiply after a prior 0xC3 result
        do_reset();
        run(13, 15, 1'b0);
        start(255, 255, 1'b0);
        cyc(3);
        lit_out("t5_prev_out", 16'h00C3, 16'h0000);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t5_ready", longint'(ready), 1);
        chk("t5_error", longint'(error), 0);
        lit_out("t5_out", 0, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk("t5_no_done", longint'(done), 0);
        end

        // Simultaneous reset and sync: sync must not be accepted
        reset = 1'b1;
        sync  = 1'b1;
        cyc(1);
        reset = 1'b0;
        sync  = 1'b0;
        cyc(1);
        chk("t6_ready", longint'(ready), 1);

        // Three back-to-back 2 x 3 accumulations from zero
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run(2, 3, 1'b1);
            chk("t7_done", longint'(done), 1);
        end
        lit_out("t7_out", 16'h0012, 16'h0000);
        chk("t7_error", longint'(error), 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            sync       = ($urandom_range(0, 4) == 0);
            input1     = DW'($urandom);
            input2     = DW'($urandom);
            accumulate = 1'($urandom);
            out_HL     = 1'($urandom);
            cyc(1);
        end
        reset = 1'b0;
        sync  = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
